// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic command sequencer: operating modes,
// sequencer state encoding and packed-command sizing.
package cordic_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } seq_state_t;

  // Packed command layout, MSB first: {mode, x, y, z}.
  localparam int CMD_W = 1 + 3 * DEFAULT_WIDTH;

  function automatic int cmd_width(input int width);
    return 1 + 3 * width;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered pointers and count-based
// full/empty flags; depth must be a power of two so pointers wrap naturally.
module cmd_fifo
  import cordic_pkg::*;
#(
  parameter int W     = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // already define which entries are valid, and resetting the array would
  // stop it mapping onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cordic_cmd_sequencer.sv
// Flow-controlled front end for the iterative cordic core: queues commands,
// drives the core for a fixed latency, then offers the results downstream.
module cordic_cmd_sequencer
  import cordic_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             cor_mode,
  output logic [WIDTH-1:0] cor_x,
  output logic [WIDTH-1:0] cor_y,
  output logic [WIDTH-1:0] cor_z,
  input  logic [WIDTH-1:0] cor_res1,
  input  logic [WIDTH-1:0] cor_res2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_res1,
  output logic [WIDTH-1:0] out_res2,
  output logic             busy
);

  localparam int CW    = cmd_width(WIDTH);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    head;
  logic             head_mode;
  logic [WIDTH-1:0] head_x, head_y, head_z;
  logic             do_pop, capture, release_out;

  assign in_ready = !fifo_full;
  assign {head_mode, head_x, head_y, head_z} = head;
  assign busy = (state_q != S_IDLE) || !fifo_empty;

  cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid && in_ready),
    .wr_data ({in_mode, in_x, in_y, in_z}),
    .pop     (do_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    do_pop      = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          do_pop  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          do_pop      = !fifo_empty;
          state_d     = fifo_empty ? S_IDLE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt       <= '0;
      cor_mode  <= MODE_ROTATE;
      cor_x     <= '0;
      cor_y     <= '0;
      cor_z     <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_res1  <= '0;
      out_res2  <= '0;
    end else begin
      state_q <= state_d;
      // Core operands change only on a pop, so they stay stable through WAIT.
      if (do_pop) begin
        cor_mode <= head_mode;
        cor_x    <= head_x;
        cor_y    <= head_y;
        cor_z    <= (head_mode == MODE_VECTOR) ? '0 : head_z;
        cnt      <= CNT_W'(LATENCY - 1);
      end else if (state_q == S_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        out_res1  <= cor_res1;
        out_res2  <= cor_res2;
        out_mode  <= cor_mode;
        out_valid <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
